// File: rtl/score_pkg.sv
// Shared definitions for the score streaming blocks.
package score_pkg;

  // Default score width and the lane element type used by score producers.
  localparam int SCORE_W = 8;
  typedef logic [SCORE_W-1:0] score_t;

  // Width of the dropped-push counter exported by the stream FIFO.
  localparam int DROP_CNT_W = 16;

  // Lane extraction helper for a packed multi-lane score word.
  function automatic score_t lane_of(input logic [63:0] word, input int lane);
    return word[lane*SCORE_W +: SCORE_W];
  endfunction

endpackage

// File: rtl/score_fifo_ram.sv
// Storage array for the score FIFO: one synchronous write port and one
// asynchronous read port so the head entry falls through without a read cycle.
module score_fifo_ram #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port: contents are never reset, only the pointers that index them.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/score_stream_fifo.sv
// First-word-fall-through FIFO carrying LANES scores per entry, with
// occupancy level, registered almost-full/almost-empty flags, synchronous
// flush and an optional drop-on-full mode with a saturating drop counter.
module score_stream_fifo
  import score_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int LANES        = 4,
  parameter int DEPTH        = 16,
  parameter int AF_LEVEL     = DEPTH - 2,
  parameter int AE_LEVEL     = 1,
  parameter int DROP_ON_FULL = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [LANES*WIDTH-1:0]   s_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [LANES*WIDTH-1:0]   m_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [DROP_CNT_W-1:0]    drop_cnt
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int DW     = LANES * WIDTH;

  localparam logic [ADDR_W:0]     DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]     AF_L    = (ADDR_W + 1)'(AF_LEVEL);
  localparam logic [ADDR_W:0]     AE_L    = (ADDR_W + 1)'(AE_LEVEL);
  localparam logic [ADDR_W-1:0]   PTR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W:0]     LVL_ONE = (ADDR_W + 1)'(1);

  // Counter increment that holds at all-ones instead of wrapping.
  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (v == {DROP_CNT_W{1'b1}}) ? v : v + DROP_CNT_W'(1);
  endfunction

  logic [ADDR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]       level_q, level_d;
  logic                  af_q, ae_q;
  logic [DROP_CNT_W-1:0] drop_cnt_q;

  logic full, empty;
  logic push, pop, drop;

  assign full  = (level_q == DEPTH_L);
  assign empty = (level_q == '0);

  // s_ready looks only at registered occupancy and rst, never at m_ready.
  assign s_ready = (DROP_ON_FULL != 0) ? !rst : (!full && !rst);
  assign m_valid = !empty;

  // A push in the flush cycle is discarded and is not counted as a drop.
  assign push = s_valid && s_ready && !full && !flush;
  assign pop  = m_valid && m_ready && !flush && !rst;
  assign drop = (DROP_ON_FULL != 0) && s_valid && full && !flush && !rst;

  // Next occupancy: flush empties; push and pop together leave level unchanged.
  always_comb begin
    level_d = level_q;
    if (flush) begin
      level_d = '0;
    end else begin
      case ({push, pop})
        2'b10:   level_d = level_q + LVL_ONE;
        2'b01:   level_d = level_q - LVL_ONE;
        default: level_d = level_q;
      endcase
    end
  end

  // Pointer, level and threshold registers; thresholds track level_d so the
  // flags line up with the level they describe in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      af_q     <= (level_d >= AF_L);
      ae_q     <= (level_d <= AE_L);
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      level_q <= level_d;
      af_q    <= (level_d >= AF_L);
      ae_q    <= (level_d <= AE_L);
    end
  end

  // Dropped-push counter; only rst clears it, flush leaves it alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_q <= '0;
    end else if (drop) begin
      drop_cnt_q <= sat_inc(drop_cnt_q);
    end
  end

  score_fifo_ram #(
    .DEPTH  (DEPTH),
    .DATA_W (DW)
  ) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (s_data),
    .raddr (rd_ptr_q),
    .rdata (m_data)
  );

  assign level        = level_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign drop_cnt     = drop_cnt_q;

endmodule
